ddr_rd_refill_ctrl: RTL and testbench

- Runs in the DDR user-clock domain and keeps the 128-bit-write / 16-bit-read prefetch read FIFO topped up.
- Watches the FIFO write-side fill level and issues fixed-length AXI read bursts to DDR3 over a circular address region.
- Streams returned beats into the FIFO write port.
- One burst is in flight at a time. Sequencing, address wrap and flush are owned here; the data bus bypasses this block.

---
 rtl/ddr_rd_refill_ctrl_if.sv | 23 ++
 rtl/ddr_rd_refill_ctrl.sv | 152 +++++++++++++++
 tb/tb_ddr_rd_refill_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_refill_ctrl_if.sv
// rtl/ddr_rd_refill_ctrl_if.sv - AXI read address/data handshake bundle for the refill controller
interface ddr_rd_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic                  axi_rvalid;
  logic                  axi_rlast;
  logic [1:0]            axi_rresp;
  logic                  axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    input  axi_arready, axi_rvalid, axi_rlast, axi_rresp
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    output axi_arready, axi_rvalid, axi_rlast, axi_rresp
  );
endinterface

// File: rtl/ddr_rd_refill_ctrl.sv
// rtl/ddr_rd_refill_ctrl.sv - DDR prefetch FIFO refill sequencer (optional stats: DDR_RD_REFILL_STAT_EN)
module ddr_rd_refill_ctrl #(
  parameter int ADDR_WIDTH       = 28,
  parameter int BURST_LEN        = 64,
  parameter int BYTES_PER_BEAT   = 16,
  parameter int FIFO_DEPTH_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_start,
  input  logic                        rd_flush,
  input  logic [ADDR_WIDTH-1:0]       rd_base_addr,
  input  logic [ADDR_WIDTH-1:0]       rd_end_addr,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_cnt,
  output logic                        fifo_wr_en,
  ddr_rd_refill_ctrl_if.master        axi,
  output logic                        busy,
`ifdef DDR_RD_REFILL_STAT_EN
  output logic [31:0]                 stat_burst_cnt,
  output logic [15:0]                 stat_err_cnt,
`endif
  output logic                        flush_done
);

  localparam int SPACE_W = FIFO_DEPTH_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, CHECK, ADDR, DATA} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  start_q;
  logic                  flush_pend;
  logic [SPACE_W-1:0]    space;
  logic                  space_ok;
  logic [ADDR_WIDTH-1:0] nxt;
  logic                  wrap;

  // Free words on the write side; fifo_wr_cnt may exceed reality, never undercount
  assign space    = SPACE_W'(1 << FIFO_DEPTH_WIDTH) - SPACE_W'(fifo_wr_cnt);
  assign space_ok = (space >= SPACE_W'(BURST_LEN));

  // Next burst start; fall back to base if the following burst would cross the end
  assign nxt  = ptr + BURST_BYTES;
  assign wrap = (nxt + BURST_BYTES) > rd_end_addr;

  assign axi.axi_arlen = 8'(BURST_LEN - 1);
  assign fifo_wr_en    = axi.axi_rvalid & axi.axi_rready;

  // Burst sequencing, region pointer and flush handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      start_q         <= 1'b0;
      flush_pend      <= 1'b0;
      flush_done      <= 1'b0;
      busy            <= 1'b0;
      axi.axi_arvalid <= 1'b0;
      axi.axi_araddr  <= '0;
      axi.axi_rready  <= 1'b0;
    end else begin
      start_q    <= rd_start;
      flush_done <= 1'b0;
      if (rd_start && !start_q) ptr <= rd_base_addr;
      case (state)
        IDLE: begin
          if (rd_flush) begin
            ptr        <= rd_base_addr;
            flush_done <= 1'b1;
          end
          if (rd_start) begin
            state <= CHECK;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (rd_flush) begin
            ptr        <= rd_base_addr;
            flush_done <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (!rd_start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (space_ok) begin
            state           <= ADDR;
            axi.axi_arvalid <= 1'b1;
            axi.axi_araddr  <= ptr;
          end
        end
        ADDR: begin
          if (rd_flush) flush_pend <= 1'b1;
          if (axi.axi_arready) begin
            axi.axi_arvalid <= 1'b0;
            axi.axi_rready  <= 1'b1;
            state           <= DATA;
            ptr             <= wrap ? rd_base_addr : nxt;
          end
        end
        DATA: begin
          if (axi.axi_rvalid && axi.axi_rlast) begin
            axi.axi_rready <= 1'b0;
            state          <= IDLE;
            busy           <= 1'b0;
            if (flush_pend || rd_flush) begin
              ptr        <= rd_base_addr;
              flush_done <= 1'b1;
              flush_pend <= 1'b0;
            end
          end else if (rd_flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_RD_REFILL_STAT_EN
  logic [7:0]  beat_idx;
  logic        beat;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign beat    = axi.axi_rvalid & axi.axi_rready;
  assign err_inc = 2'((axi.axi_rresp != 2'b00)) +
                   2'(axi.axi_rlast && (beat_idx != 8'(BURST_LEN - 1)));
  assign err_sum = {1'b0, stat_err_cnt} + 17'(err_inc);

  // Burst count wraps; error count saturates; beat index restarts on every AR handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_burst_cnt <= '0;
      stat_err_cnt   <= '0;
      beat_idx       <= '0;
    end else begin
      if (axi.axi_arvalid && axi.axi_arready) begin
        stat_burst_cnt <= stat_burst_cnt + 32'd1;
        beat_idx       <= '0;
      end else if (beat) begin
        beat_idx <= beat_idx + 8'd1;
      end
      if (beat) stat_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^axi.axi_rresp;
`endif

endmodule

// File: tb/tb_ddr_rd_refill_ctrl.sv
// tb/tb_ddr_rd_refill_ctrl.sv - self-checking bench for ddr_rd_refill_ctrl
module tb_ddr_rd_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_start = 1'b0;
  logic        rd_flush = 1'b0;
  logic [27:0] rd_base_addr = '0;
  logic [27:0] rd_end_addr = 28'h4000;
  logic [10:0] fifo_wr_cnt = '0;
  logic        fifo_wr_en;
  logic        busy;
  logic        flush_done;
`ifdef DDR_RD_REFILL_STAT_EN
  logic [31:0] stat_burst_cnt;
  logic [15:0] stat_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ddr_rd_refill_ctrl_if #(.ADDR_WIDTH(28)) bus();

  ddr_rd_refill_ctrl dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_flush(rd_flush),
    .rd_base_addr(rd_base_addr), .rd_end_addr(rd_end_addr),
    .fifo_wr_cnt(fifo_wr_cnt), .fifo_wr_en(fifo_wr_en), .axi(bus),
    .busy(busy),
`ifdef DDR_RD_REFILL_STAT_EN
    .stat_burst_cnt(stat_burst_cnt), .stat_err_cnt(stat_err_cnt),
`endif
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic        start, flush;
    logic [10:0] cnt;
    logic        arready, rvalid, rlast;
    logic        e_arvalid, e_rready, e_busy, e_fdone, e_wren;
    logic [27:0] e_araddr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic s, f, input logic [10:0] c,
                              input logic ar, rv, rl, av, rr, bz, fd, we,
                              input logic [27:0] a);
    vec_t v;
    v.start = s; v.flush = f; v.cnt = c; v.arready = ar; v.rvalid = rv; v.rlast = rl;
    v.e_arvalid = av; v.e_rready = rr; v.e_busy = bz; v.e_fdone = fd; v.e_wren = we;
    v.e_araddr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rlast   = 1'b0;
    bus.axi_rresp   = 2'b00;
  endtask

  // Waits for AR, optionally stalls it, then returns 64 beats with rlast on the last
  task automatic do_burst(input int ar_wait, input int flush_beat, input int err_beats,
                          output logic [27:0] addr, output int wr_seen, output int fd_after);
    int n;
    n = 0;
    wr_seen = 0;
    @(negedge clk); bus.axi_arready = 1'b0; #1;
    while (!bus.axi_arvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.axi_arvalid) chk("ar_timeout", 32'd0, 32'd1);
    addr = bus.axi_araddr;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk); bus.axi_arready = 1'b0; #1;
      chk("ar_hold_valid", {31'd0, bus.axi_arvalid}, 32'd1);
      chk("ar_hold_addr", {4'd0, bus.axi_araddr}, {4'd0, addr});
    end
    @(negedge clk); bus.axi_arready = 1'b1; #1;
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b1;
      bus.axi_rlast   = (b == 63);
      bus.axi_rresp   = (b < err_beats) ? 2'b10 : 2'b00;
      rd_flush        = (b == flush_beat);
      #1;
      if (fifo_wr_en) wr_seen++;
    end
    @(negedge clk); idle_bus(); rd_flush = 1'b0; #1;
    fd_after = int'(flush_done);
  endtask

  logic [27:0] a;
  int          w, fd, n;

  initial begin
    idle_bus();
    vecs[0]  = mk(0,0,961, 0,0,0, 0,0,0,0,0,28'h0);
    vecs[1]  = mk(1,0,961, 0,0,0, 0,0,0,0,0,28'h0);
    vecs[2]  = mk(1,0,961, 0,0,0, 0,0,1,0,0,28'h0);
    vecs[3]  = mk(1,0,961, 0,0,0, 0,0,1,0,0,28'h0);
    vecs[4]  = mk(1,0,960, 0,0,0, 0,0,1,0,0,28'h0);
    vecs[5]  = mk(1,0,960, 0,0,0, 1,0,1,0,0,28'h0);
    vecs[6]  = mk(1,0,960, 1,0,0, 1,0,1,0,0,28'h0);
    vecs[7]  = mk(1,0,960, 0,1,0, 0,1,1,0,1,28'h0);
    vecs[8]  = mk(1,0,960, 0,0,0, 0,1,1,0,0,28'h0);
    vecs[9]  = mk(1,0,960, 0,1,1, 0,1,1,0,1,28'h0);
    vecs[10] = mk(1,0,0,   0,0,0, 0,0,0,0,0,28'h0);
    vecs[11] = mk(1,0,0,   0,0,0, 0,0,1,0,0,28'h0);
    vecs[12] = mk(1,0,0,   0,0,0, 1,0,1,0,0,28'h400);
    vecs[13] = mk(0,1,0,   1,0,0, 1,0,1,0,0,28'h400);
    vecs[14] = mk(0,0,0,   0,1,1, 0,1,1,0,1,28'h400);
    vecs[15] = mk(0,0,0,   0,0,0, 0,0,0,1,0,28'h400);
    vecs[16] = mk(0,0,0,   0,0,0, 0,0,0,0,0,28'h400);
    vecs[17] = mk(1,0,1000,0,0,0, 0,0,0,0,0,28'h400);
    vecs[18] = mk(1,1,1000,0,0,0, 0,0,1,0,0,28'h400);
    vecs[19] = mk(1,0,0,   0,0,0, 0,0,0,1,0,28'h400);
    vecs[20] = mk(1,0,0,   0,0,0, 0,0,1,0,0,28'h400);
    vecs[21] = mk(1,0,0,   0,0,0, 1,0,1,0,0,28'h0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rd_start = vecs[i].start; rd_flush = vecs[i].flush; fifo_wr_cnt = vecs[i].cnt;
      bus.axi_arready = vecs[i].arready; bus.axi_rvalid = vecs[i].rvalid;
      bus.axi_rlast = vecs[i].rlast;
      #1;
      chk($sformatf("v%0d_arvalid", i), {31'd0, bus.axi_arvalid}, {31'd0, vecs[i].e_arvalid});
      chk($sformatf("v%0d_rready", i), {31'd0, bus.axi_rready}, {31'd0, vecs[i].e_rready});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_flush_done", i), {31'd0, flush_done}, {31'd0, vecs[i].e_fdone});
      chk($sformatf("v%0d_wr_en", i), {31'd0, fifo_wr_en}, {31'd0, vecs[i].e_wren});
      chk($sformatf("v%0d_araddr", i), {4'd0, bus.axi_araddr}, {4'd0, vecs[i].e_araddr});
    end

    // Fresh start: latency, full bursts, flush mid-burst, AR backpressure
    @(negedge clk); rst = 1'b1; rd_start = 1'b0; rd_flush = 1'b0; fifo_wr_cnt = '0; idle_bus();
    @(negedge clk); rst = 1'b0;
    rd_base_addr = 28'h0; rd_end_addr = 28'h4000;
    @(negedge clk); rd_start = 1'b1; #1;
    chk("lat_c0", {31'd0, bus.axi_arvalid}, 32'd0);
    @(negedge clk); #1;
    chk("lat_c1", {31'd0, bus.axi_arvalid}, 32'd0);
    @(negedge clk); #1;
    chk("lat_c2", {31'd0, bus.axi_arvalid}, 32'd1);
    chk("arlen", {24'd0, bus.axi_arlen}, 32'd63);

    do_burst(0, -1, 0, a, w, fd);
    chk("b1_addr", {4'd0, a}, 32'h0);
    chk("b1_wr", w, 64);
    do_burst(0, 10, 0, a, w, fd);
    chk("b2_addr", {4'd0, a}, 32'h400);
    chk("b2_wr", w, 64);
    chk("b2_flush_done", fd, 1);
    do_burst(5, -1, 3, a, w, fd);
    chk("b3_addr_after_flush", {4'd0, a}, 32'h0);
    chk("b3_wr", w, 64);
    chk("b3_no_flush_done", fd, 0);
`ifdef DDR_RD_REFILL_STAT_EN
    chk("stat_err", {16'd0, stat_err_cnt}, 32'd3);
    chk("stat_burst", stat_burst_cnt, 32'd3);
`endif

    // Reset while an AR is pending
    n = 0;
    @(negedge clk); #1;
    while (!bus.axi_arvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("b4_arvalid", {31'd0, bus.axi_arvalid}, 32'd1);
    chk("b4_addr", {4'd0, bus.axi_araddr}, 32'h400);
    rst = 1'b1; #1;
    chk("rst_arvalid", {31'd0, bus.axi_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, bus.axi_rready}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_araddr", {4'd0, bus.axi_araddr}, 32'h0);
    chk("rst_ptr", {4'd0, dut.ptr}, 32'h0);
`ifdef DDR_RD_REFILL_STAT_EN
    chk("rst_stat_burst", stat_burst_cnt, 32'd0);
    chk("rst_stat_err", {16'd0, stat_err_cnt}, 32'd0);
`endif

    // Small region: address sequence wraps back to base
    @(negedge clk); rst = 1'b0; rd_end_addr = 28'h800;
    do_burst(0, -1, 0, a, w, fd);
    chk("wrap_a0", {4'd0, a}, 32'h0);
    do_burst(0, -1, 0, a, w, fd);
    chk("wrap_a1", {4'd0, a}, 32'h400);
    do_burst(0, -1, 0, a, w, fd);
    chk("wrap_a2", {4'd0, a}, 32'h0);
    chk("wrap_wr", w, 64);

    rd_start = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
